// File: rtl/cluster_pkg.sv
// Shared constants and FSM state type for the k-means assignment block.
package cluster_pkg;

  localparam int COORD_W  = 8;
  localparam int DIST_W   = 16;
  localparam int DIST_LAT = 3;
  localparam logic [DIST_W-1:0] DIST_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/distance.sv
// Three-stage scaled squared Euclidean distance: floor((dx^2 + dy^2) / 2).
// Stage 1 absolute differences, stage 2 squares, stage 3 halved sum.
module distance
  import cluster_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic [DIST_W-1:0]  sq_distance
);

  logic [COORD_W-1:0] r_dx, r_dy;
  logic [DIST_W-1:0]  r_sqx, r_sqy;
  logic [DIST_W-1:0]  w_dx_ext, w_dy_ext;
  logic [DIST_W:0]    w_sum;

  assign w_dx_ext = {{(DIST_W-COORD_W){1'b0}}, r_dx};
  assign w_dy_ext = {{(DIST_W-COORD_W){1'b0}}, r_dy};
  assign w_sum    = {1'b0, r_sqx} + {1'b0, r_sqy};

  // Pipeline registers: abs diff, square, halved sum (sum needs 17 bits before the shift).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dx        <= '0;
      r_dy        <= '0;
      r_sqx       <= '0;
      r_sqy       <= '0;
      sq_distance <= '0;
    end else begin
      r_dx        <= (ax > bx) ? (ax - bx) : (bx - ax);
      r_dy        <= (ay > by) ? (ay - by) : (by - ay);
      r_sqx       <= w_dx_ext * w_dx_ext;
      r_sqy       <= w_dy_ext * w_dy_ext;
      sq_distance <= w_sum[DIST_W:1];
    end
  end

endmodule

// File: rtl/nearest_centroid.sv
// Nearest-centroid scheduler: streams the active centroids through one shared
// distance pipeline and keeps the running minimum (ties keep the lowest index).
module nearest_centroid
  import cluster_pkg::*;
#(
  parameter int K_MAX = 16,
  parameter int IDX_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen_we,
  input  logic [IDX_W-1:0]   cen_addr,
  input  logic [COORD_W-1:0] cen_x,
  input  logic [COORD_W-1:0] cen_y,
  input  logic [IDX_W:0]     k_num,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [COORD_W-1:0] pt_x,
  input  logic [COORD_W-1:0] pt_y,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [IDX_W-1:0]   res_idx,
  output logic [DIST_W-1:0]  res_dist,
  output logic               busy
);

  localparam logic [IDX_W:0] KMAX_L = (IDX_W+1)'(K_MAX);
  localparam logic [IDX_W:0] ONE_K  = (IDX_W+1)'(1);

  state_t r_state, w_state_next;

  logic [COORD_W-1:0] r_tab_x [K_MAX];
  logic [COORD_W-1:0] r_tab_y [K_MAX];
  logic [COORD_W-1:0] r_px, r_py;
  logic [IDX_W:0]     r_kn;
  logic [IDX_W-1:0]   r_cnt;
  logic [DIST_LAT-1:0] r_vld;
  logic [IDX_W-1:0]   r_idx_sr [DIST_LAT];
  logic [DIST_W-1:0]  r_best_dist;
  logic [IDX_W-1:0]   r_best_idx;

  logic               w_accept, w_issue, w_last_issue, w_drained;
  logic [IDX_W:0]     w_kn;
  logic [DIST_W-1:0]  w_sq_dist;

  assign w_accept     = (r_state == S_IDLE) && pt_valid;
  assign w_issue      = (r_state == S_ISSUE);
  assign w_kn         = (k_num > KMAX_L) ? KMAX_L : k_num;
  assign w_last_issue = w_issue && ({1'b0, r_cnt} == (r_kn - ONE_K));
  // Only the entry now leaving the pipeline may still be valid.
  assign w_drained    = (r_vld[DIST_LAT-2:0] == '0);

  assign pt_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign res_valid = (r_state == S_DONE);
  assign res_idx   = r_best_idx;
  assign res_dist  = r_best_dist;

  // Centroid table: each entry writable only while idle so a scan sees a frozen table.
  generate
    for (genvar gi = 0; gi < K_MAX; gi++) begin : g_tab
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tab_x[gi] <= '0;
          r_tab_y[gi] <= '0;
        end else if ((r_state == S_IDLE) && cen_we && (cen_addr == IDX_W'(gi))) begin
          r_tab_x[gi] <= cen_x;
          r_tab_y[gi] <= cen_y;
        end
      end
    end
  endgenerate

  distance u_distance (
    .clk         (clk),
    .rst         (rst),
    .ax          (r_tab_x[r_cnt]),
    .ay          (r_tab_y[r_cnt]),
    .bx          (r_px),
    .by          (r_py),
    .sq_distance (w_sq_dist)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next state; an empty request skips the scan entirely.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (pt_valid) w_state_next = (k_num == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_last_issue) w_state_next = S_DRAIN;
      S_DRAIN: if (w_drained) w_state_next = S_DONE;
      S_DONE:  if (res_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Valid and index tags travel alongside the distance pipeline; bubbles carry valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < DIST_LAT; i++) r_idx_sr[i] <= '0;
    end else begin
      r_vld       <= {r_vld[DIST_LAT-2:0], w_issue};
      r_idx_sr[0] <= r_cnt;
      for (int i = 1; i < DIST_LAT; i++) r_idx_sr[i] <= r_idx_sr[i-1];
    end
  end

  // Request latch, issue counter and running minimum (strict compare keeps lowest index on ties).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_px        <= '0;
      r_py        <= '0;
      r_kn        <= '0;
      r_cnt       <= '0;
      r_best_dist <= '0;
      r_best_idx  <= '0;
    end else if (w_accept) begin
      r_px        <= pt_x;
      r_py        <= pt_y;
      r_kn        <= w_kn;
      r_cnt       <= '0;
      r_best_dist <= DIST_MAX;
      r_best_idx  <= '0;
    end else begin
      if (w_issue) r_cnt <= r_cnt + IDX_W'(1);
      if (r_vld[DIST_LAT-1] && (w_sq_dist < r_best_dist)) begin
        r_best_dist <= w_sq_dist;
        r_best_idx  <= r_idx_sr[DIST_LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_nearest_centroid.sv
// Directed bench for nearest_centroid with hand-computed expected results.
module tb_nearest_centroid;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen_we = 1'b0;
  logic [3:0]  cen_addr = '0;
  logic [7:0]  cen_x = '0, cen_y = '0;
  logic [4:0]  k_num = '0;
  logic        pt_valid = 1'b0;
  logic        pt_ready;
  logic [7:0]  pt_x = '0, pt_y = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [3:0]  res_idx;
  logic [15:0] res_dist;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  nearest_centroid #(.K_MAX(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .cen_we(cen_we), .cen_addr(cen_addr),
    .cen_x(cen_x), .cen_y(cen_y), .k_num(k_num),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
    .res_dist(res_dist), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic write_cen(input logic [3:0] a, input logic [7:0] x, input logic [7:0] y);
    cen_we = 1'b1; cen_addr = a; cen_x = x; cen_y = y;
    tick();
    cen_we = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!res_valid && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  // One request: accept, wait for the result, optionally stall the consumer, then release.
  task automatic run_point(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic [4:0] k, input logic [3:0] e_idx,
                           input logic [15:0] e_dist, input int e_lat, input int hold_n);
    int lat;
    pt_x = x; pt_y = y; k_num = k; pt_valid = 1'b1;
    check({tag, "_ready"}, pt_ready, 1);
    tick();
    pt_valid = 1'b0;
    check({tag, "_ready_fall"}, pt_ready, 0);
    wait_result(lat);
    check({tag, "_lat"}, lat, e_lat);
    check({tag, "_idx"}, res_idx, e_idx);
    check({tag, "_dist"}, res_dist, e_dist);
    check({tag, "_busy"}, busy, 1);
    $display("txn %s: pt=(%0d,%0d) k=%0d -> idx=%0d dist=%0d lat=%0d", tag, x, y, k, res_idx, res_dist, lat);
    for (int i = 0; i < hold_n; i++) begin
      pt_valid = 1'b1;
      tick();
      check({tag, "_hold_valid"}, res_valid, 1);
      check({tag, "_hold_idx"}, res_idx, e_idx);
      check({tag, "_hold_dist"}, res_dist, e_dist);
      check({tag, "_hold_ready"}, pt_ready, 0);
    end
    pt_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_released"}, res_valid, 0);
    check({tag, "_idle"}, pt_ready, 1);
  endtask

  initial begin
    int lat;
    // Reset state, observed in the cycle after a reset edge.
    tick();
    check("rst_ready", pt_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_idx", res_idx, 0);
    check("rst_res_dist", res_dist, 0);
    rst = 1'b0;
    // Freshly reset table: all 16 entries at (0,0), dist (9+16)/2 = 12, tie -> idx 0.
    run_point("rst_table", 8'd3, 8'd4, 5'd16, 4'd0, 16'd12, 20, 0);

    // Basic: nearest is (10,10) from (12,9): (4+1)/2 = 2.
    write_cen(4'd0, 8'd0, 8'd0);
    write_cen(4'd1, 8'd10, 8'd10);
    write_cen(4'd2, 8'd200, 8'd50);
    run_point("basic", 8'd12, 8'd9, 5'd3, 4'd1, 16'd2, 7, 0);

    // Tie between entries 0 and 2 keeps index 0; consumer stalls 10 cycles with pt_valid high.
    write_cen(4'd0, 8'd5, 8'd5);
    write_cen(4'd2, 8'd5, 8'd5);
    run_point("tie_hold", 8'd5, 8'd5, 5'd3, 4'd0, 16'd0, 7, 10);

    // Maximum distance: (255^2 * 2) / 2 = 65025.
    write_cen(4'd0, 8'd0, 8'd0);
    run_point("max_dist", 8'd255, 8'd255, 5'd1, 4'd0, 16'd65025, 5, 0);

    // Empty request.
    run_point("k_zero", 8'd7, 8'd7, 5'd0, 4'd0, 16'hFFFF, 1, 0);

    // k_num beyond K_MAX clamps to 16; only entry 15 matches, (0+1)/2 = 0.
    write_cen(4'd15, 8'd100, 8'd100);
    run_point("k_clamp", 8'd100, 8'd101, 5'd31, 4'd15, 16'd0, 20, 0);

    // Table write attempted throughout a scan must be ignored.
    // Table now: 0=(0,0) 1=(10,10) 2=(5,5).
    pt_x = 8'd10; pt_y = 8'd10; k_num = 5'd3; pt_valid = 1'b1;
    tick();
    pt_valid = 1'b0;
    cen_we = 1'b1; cen_addr = 4'd2; cen_x = 8'd200; cen_y = 8'd200;
    wait_result(lat);
    cen_we = 1'b0;
    check("we_scan_lat", lat, 7);
    check("we_scan_idx", res_idx, 1);
    check("we_scan_dist", res_dist, 0);
    $display("txn we_scan: pt=(10,10) k=3 -> idx=%0d dist=%0d lat=%0d", res_idx, res_dist, lat);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    // Untouched entry 2=(5,5) gives 38025; entry 1=(10,10) gives 36100 and wins.
    run_point("we_after", 8'd200, 8'd200, 5'd3, 4'd1, 16'd36100, 7, 0);

    // Reset during issue index 2 aborts the scan and clears the table.
    pt_x = 8'd9; pt_y = 8'd9; k_num = 5'd16; pt_valid = 1'b1;
    tick();
    pt_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort_ready", pt_ready, 1);
    check("abort_valid", res_valid, 0);
    check("abort_busy", busy, 0);
    $display("txn abort: reset at issue index 2");
    rst = 1'b0;
    // All entries (0,0) from (1,1): (1+1)/2 = 1, idx 0; a stale bubble would report 0.
    run_point("post_abort", 8'd1, 8'd1, 5'd4, 4'd0, 16'd1, 8, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nearest_centroid.md
# nearest_centroid

Scheduler for the k-means assignment step. Holds a table of up to K_MAX centroids and accepts one point per request. Streams the active centroids, one per cycle, through a single shared `distance` pipeline, then tracks the running minimum. Returns the index and scaled squared distance of the nearest centroid, so downstream update logic sees exactly one result per point.

## Interface
- K_MAX, 16: centroid table depth, power of two.
- IDX_W, 4: index width, log2(K_MAX).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: rst, synchronous, active-high; clock clk.
- cen_we  in  1  centroid table write strobe.
- cen_addr  in  IDX_W  table write address.
- cen_x, cen_y  in  8 each  centroid coordinates (unsigned).
- k_num  in  IDX_W+1  active centroid count, sampled at point accept.
- pt_valid  in  1  point request valid.
- pt_ready  out  1  point request ready.
- pt_x, pt_y  in  8 each  point coordinates (unsigned).
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted by consumer.
- res_idx  out  IDX_W  nearest centroid index.
- res_dist  out  16  its distance, floor((dx²+dy²)/2), range 0..65025.
- busy  out  1  high in every state other than IDLE.

## Operation
- FSM states:
  - IDLE: pt_ready=1.
  - ISSUE: one centroid per cycle into `distance`.
  - DRAIN: waits until the pipeline is empty.
  - DONE: res_valid=1.
- Transitions:
  - IDLE→ISSUE on pt_valid&&pt_ready.
  - At that accept edge, pt_x/pt_y are latched, kn=min(k_num,K_MAX) is latched, the issue counter is cleared, and best_dist is set to 16'hFFFF.
  - ISSUE→DRAIN after issue index kn-1.
  - DRAIN→DONE once the 3-deep valid shift register is empty and the last compare has completed.
  - DONE→IDLE on res_ready.
- k_num=0: IDLE→DONE directly with res_idx=0, res_dist=16'hFFFF, and no issues.
- Compare rule: when a result exits the pipeline with dist < best_dist (strict), update best_dist and best_idx. Ties therefore keep the lowest index.
- Index alignment: the centroid index travels in a 3-stage shift register parallel to the valid bits.
- Table writes: cen_we is honoured only in IDLE and ignored otherwise. This makes the table constant for the whole scan.
- Table read path: the table is a register array read combinationally. The issue address comes from the registered issue counter.
- `distance` rst is tied to rst. Bubble cycles are tagged invalid and never compared.
- res_idx/res_dist hold stable while res_valid=1 and res_ready=0.

## Timing
- Cycle convention: accept edge ends cycle T.
  - Centroid i is issued in cycle T+1+i.
  - Its distance appears on sq_distance in cycle T+4+i and is compared at the end of that cycle.
- res_valid rises in cycle T+kn+4, so latency is kn+4 cycles; k_num=0 gives 1 cycle.
- Throughput: one point per kn+5 cycles with res_ready held high.
- pt_ready falls on the cycle after accept.
- Reset values, in the cycle after a reset edge:
  - state IDLE, pt_ready=1, busy=0.
  - res_valid=0, res_idx=0, res_dist=0.
  - all table entries 0.
  - valid shift register cleared.
- Reset mid-scan aborts immediately. No result is produced, and bubbles from the aborted scan never reach the comparator.
- res_ready while res_valid=0 is ignored.
- pt_valid held high during a scan is not accepted until the cycle after DONE→IDLE.

## Structure
- Shared package (`cluster_pkg`):
  - COORD_W=8, DIST_W=16, DIST_LAT=3.
  - DIST_MAX=16'hFFFF.
  - state enum.
- One sub-module: the existing `distance` pipeline, instantiated once.
- DIST_LAT must match the depth of that pipeline.

## Test plan
- Load centroids {(0,0),(10,10),(200,50)}, point (12,9), k_num=3 → res_idx=1, res_dist=2, res_valid in cycle T+7.
- Centroids 0 and 2 both at (5,5), point (5,5), k_num=3 → res_idx=0, res_dist=0.
- Centroid 0=(0,0), point (255,255), k_num=1 → res_dist=65025, res_idx=0.
- Extreme k_num values:
  - k_num=0 → res_idx=0, res_dist=FFFF one cycle after accept.
  - k_num=31 with K_MAX=16 → scans 16 entries, latency 20.
- Protocol stress:
  - Hold res_ready=0 for 10 cycles → outputs stable, pt_ready=0.
  - Issue cen_we during the scan → table unchanged.
- Assert rst at issue index 2 → next cycle IDLE, pt_ready=1, res_valid=0. A fresh request then gives a correct result with no stale compares.
